// File: rtl/ghost_move_executor_if.sv
// Ghost move executor bus: direction handshake, maze-map read port and position outputs.
// The master drives commands, game ticks and map data; the slave is the executor.
interface ghost_move_executor_if #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int AW = XW + YW;

  logic          update;
  logic          dir_valid;
  logic [1:0]    dir;
  logic          dir_ready;
  logic          map_rd;
  logic [AW-1:0] map_addr;
  logic          map_wall;
  logic [AW-1:0] pos;
  logic [XW-1:0] posX;
  logic [YW-1:0] posY;
  logic          moved;
  logic          blocked;

  modport slave (
    input  update, dir_valid, dir, map_wall,
    output dir_ready, map_rd, map_addr, pos, posX, posY, moved, blocked
  );

  modport master (
    output update, dir_valid, dir, map_wall,
    input  dir_ready, map_rd, map_addr, pos, posX, posY, moved, blocked
  );
endinterface

// File: rtl/ghost_move_executor.sv
// Executes one ghost step per move credit: computes the destination tile, reads the maze map
// one cycle later, and commits or rejects the move. Credits are earned from game-tick pulses.
module ghost_move_executor #(
  parameter int GRID_W         = 32,
  parameter int GRID_H         = 32,
  parameter int START_POS      = 0,
  parameter int TICKS_PER_MOVE = 4
) (
  input logic                   clk,
  input logic                   reset,
  ghost_move_executor_if.slave  bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int AW = XW + YW;
  localparam int TW = (TICKS_PER_MOVE > 1) ? $clog2(TICKS_PER_MOVE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [AW-1:0] cand_q, cand_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          credit_q, credit_d;
  logic          dir_ready_q, dir_ready_d;
  logic          map_rd_q, map_rd_d;
  logic [AW-1:0] map_addr_q, map_addr_d;
  logic          moved_q, moved_d;
  logic          blocked_q, blocked_d;

  logic [XW-1:0] x_s;
  logic [YW-1:0] y_s;
  logic [AW-1:0] cand_s;
  logic          edge_s;
  logic          handshake_s;
  logic          wrap_s;
  logic          consume_s;

  assign x_s         = pos_q[XW-1:0];
  assign y_s         = pos_q[AW-1:XW];
  assign handshake_s = bus.dir_valid & dir_ready_q;
  assign wrap_s      = bus.update & (tick_q == TW'(TICKS_PER_MOVE - 1));

  // Destination tile; x wraps through the tunnel, y stops at the maze border.
  always_comb begin
    cand_s = pos_q;
    edge_s = 1'b0;
    case (bus.dir)
      2'b00: begin
        cand_s = {y_s - YW'(1), x_s};
        edge_s = (y_s == YW'(0));
      end
      2'b01: cand_s = {y_s, x_s + XW'(1)};
      2'b10: begin
        cand_s = {y_s + YW'(1), x_s};
        edge_s = (y_s == YW'(GRID_H - 1));
      end
      2'b11: cand_s = {y_s, x_s - XW'(1)};
      default: begin
        cand_s = pos_q;
        edge_s = 1'b0;
      end
    endcase
  end

  // Next-state logic for pacing, the move FSM and the registered outputs.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    cand_d     = cand_q;
    map_rd_d   = 1'b0;
    map_addr_d = '0;
    moved_d    = 1'b0;
    blocked_d  = 1'b0;
    consume_s  = 1'b0;

    if (bus.update) begin
      tick_d = wrap_s ? TW'(0) : tick_q + TW'(1);
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      S_IDLE: begin
        if (handshake_s && edge_s) begin
          blocked_d = 1'b1;
          consume_s = 1'b1;
        end else if (handshake_s) begin
          cand_d     = cand_s;
          map_rd_d   = 1'b1;
          map_addr_d = cand_s;
          state_d    = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.map_wall) begin
          blocked_d = 1'b1;
        end else begin
          pos_d   = cand_q;
          moved_d = 1'b1;
        end
        consume_s = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A wrap in the consuming cycle re-arms the credit; otherwise the clear wins.
    if (consume_s) begin
      credit_d = wrap_s;
    end else if (wrap_s) begin
      credit_d = 1'b1;
    end else begin
      credit_d = credit_q;
    end

    dir_ready_d = (state_d == S_IDLE) & credit_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pos_q       <= AW'(START_POS);
      cand_q      <= '0;
      tick_q      <= '0;
      credit_q    <= 1'b0;
      dir_ready_q <= 1'b0;
      map_rd_q    <= 1'b0;
      map_addr_q  <= '0;
      moved_q     <= 1'b0;
      blocked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cand_q      <= cand_d;
      tick_q      <= tick_d;
      credit_q    <= credit_d;
      dir_ready_q <= dir_ready_d;
      map_rd_q    <= map_rd_d;
      map_addr_q  <= map_addr_d;
      moved_q     <= moved_d;
      blocked_q   <= blocked_d;
    end
  end

  assign bus.dir_ready = dir_ready_q;
  assign bus.map_rd    = map_rd_q;
  assign bus.map_addr  = map_addr_q;
  assign bus.pos       = pos_q;
  assign bus.posX      = pos_q[XW-1:0];
  assign bus.posY      = pos_q[AW-1:XW];
  assign bus.moved     = moved_q;
  assign bus.blocked   = blocked_q;
endmodule
